// File: rtl/hellorld_rx_pkg.sv
// Shared definitions for the Hellorld receive chain: message table, resync character,
// receiver FSM encoding and the smallest usable baud divisor.
package hellorld_rx_pkg;

    localparam int        MSG_LEN     = 11;
    localparam int        MIN_DIV     = 3;
    localparam logic [7:0] RESYNC_CHAR = 8'h48;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // "Hellorld!\r\n", indexed 0..MSG_LEN-1
    function automatic logic [7:0] msg_char(input logic [3:0] idx);
        case (idx)
            4'd0:    msg_char = 8'h48;
            4'd1:    msg_char = 8'h65;
            4'd2:    msg_char = 8'h6C;
            4'd3:    msg_char = 8'h6C;
            4'd4:    msg_char = 8'h6F;
            4'd5:    msg_char = 8'h72;
            4'd6:    msg_char = 8'h6C;
            4'd7:    msg_char = 8'h64;
            4'd8:    msg_char = 8'h21;
            4'd9:    msg_char = 8'h0D;
            4'd10:   msg_char = 8'h0A;
            default: msg_char = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/hellorld_rx_if.sv
// Serial line, divisor and receive/checker results of the Hellorld receiver.
interface hellorld_rx_if #(
    parameter int DIV_W = 12,
    parameter int CNT_W = 8
);
    logic             rx_in;
    logic [DIV_W-1:0] custom_settings;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             frame_err;
    logic             rx_busy;
    logic             msg_ok;
    logic [CNT_W-1:0] msg_count;

    modport slave (
        input  rx_in, custom_settings,
        output rx_data, rx_valid, frame_err, rx_busy, msg_ok, msg_count
    );

    modport master (
        output rx_in, custom_settings,
        input  rx_data, rx_valid, frame_err, rx_busy, msg_ok, msg_count
    );
endinterface

// File: rtl/hellorld_rx_core.sv
// UART 8N1 receive core: input synchronizer, baud counter, FSM and shift register.
// RX_MAJORITY_EN selects a 2-of-3 vote over the last three clocks of each bit.
module hellorld_rx_core
    import hellorld_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 12
) (
    input  logic             wb_clk_i,
    input  logic             rst_n,
    input  logic             rx_in,
    input  logic [DIV_W-1:0] custom_settings,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             frame_err,
    output logic             rx_busy
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs, rxs_d;
    rx_state_t              state_q, state_d;
    logic [DIV_W-1:0]       baud_q, baud_d, div_q, div_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d, rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
    logic                   sample_bit, sample_now, fall_edge;

    assign rxs        = sync_q[SYNC_STAGES-1];
    assign fall_edge  = rxs_d & ~rxs;
    assign sample_now = (baud_q == '0);

`ifdef RX_MAJORITY_EN
    logic [1:0] vote_q;

    assign sample_bit = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxs) | (vote_q[0] & rxs);

    // Line is known low at the start edge, so a short START count votes against a stale 0
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            vote_q <= 2'b00;
        end else if (state_q == ST_IDLE) begin
            vote_q <= 2'b00;
        end else if (baud_q == DIV_W'(2) || baud_q == DIV_W'(1)) begin
            vote_q <= {vote_q[0], rxs};
        end
    end
`else
    assign sample_bit = rxs;
`endif

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '1;
            rxs_d       <= 1'b1;
            state_q     <= ST_IDLE;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], rx_in};
            rxs_d       <= rxs;
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        div_q   <= div_d;
        shift_q <= shift_d;
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        div_d       = div_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fall_edge && custom_settings >= DIV_W'(MIN_DIV)) begin
                    div_d   = custom_settings;
                    baud_d  = custom_settings >> 1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (!sample_now) begin
                    baud_d = baud_q - DIV_W'(1);
                end else if (!sample_bit) begin
                    baud_d    = div_q;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!sample_now) begin
                    baud_d = baud_q - DIV_W'(1);
                end else begin
                    shift_d   = {sample_bit, shift_q[7:1]};
                    baud_d    = div_q;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (!sample_now) begin
                    baud_d = baud_q - DIV_W'(1);
                end else if (sample_bit) begin
                    rx_data_d  = shift_q;
                    rx_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: rtl/hellorld_rx.sv
// Hellorld receiver top: UART core plus "Hellorld!\r\n" message checker and match counter.
// Build option RX_MAJORITY_EN (in the core) enables majority-vote bit sampling.
module hellorld_rx
    import hellorld_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 12,
    parameter int CNT_W       = 8
) (
    input  logic          wb_clk_i,
    input  logic          rst_n,
    hellorld_rx_if.slave  bus
);

    logic [7:0]       rx_data;
    logic             rx_valid, frame_err, rx_busy;
    logic [3:0]       idx_q;
    logic             msg_ok_q;
    logic [CNT_W-1:0] msg_count_q;

    hellorld_rx_core #(
        .SYNC_STAGES (SYNC_STAGES),
        .DIV_W       (DIV_W)
    ) u_core (
        .wb_clk_i        (wb_clk_i),
        .rst_n           (rst_n),
        .rx_in           (bus.rx_in),
        .custom_settings (bus.custom_settings),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .frame_err       (frame_err),
        .rx_busy         (rx_busy)
    );

    // A mismatching 'H' may itself begin a new message, so it resyncs to index 1
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            msg_ok_q    <= 1'b0;
            msg_count_q <= '0;
        end else begin
            msg_ok_q <= 1'b0;
            if (frame_err) begin
                idx_q <= '0;
            end else if (rx_valid) begin
                if (rx_data == msg_char(idx_q)) begin
                    if (idx_q == 4'(MSG_LEN - 1)) begin
                        idx_q    <= '0;
                        msg_ok_q <= 1'b1;
                        if (msg_count_q != '1) msg_count_q <= msg_count_q + CNT_W'(1);
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end else begin
                    idx_q <= (rx_data == RESYNC_CHAR) ? 4'd1 : 4'd0;
                end
            end
        end
    end

    assign bus.rx_data   = rx_data;
    assign bus.rx_valid  = rx_valid;
    assign bus.frame_err = frame_err;
    assign bus.rx_busy   = rx_busy;
    assign bus.msg_ok    = msg_ok_q;
    assign bus.msg_count = msg_count_q;

endmodule

// File: tb/tb_hellorld_rx.sv
// Scoreboard bench for hellorld_rx: serial frames driven cycle-accurately, bytes checked on rx_valid.
module tb_hellorld_rx;

    localparam int SYNC  = 2;
    localparam int DIV_W = 12;
    localparam int CNT_W = 8;
    localparam logic [7:0] MSG [11] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h72,
                                        8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hellorld_rx_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    hellorld_rx #(.SYNC_STAGES(SYNC), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .wb_clk_i (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         n_valid = 0, n_ferr = 0, n_ok = 0;
    int         last_valid_cyc = 0, start_cyc = 0;
    int         div = 15;
    int         v0, f0, k0;
    logic [7:0] exp_q [$];
    logic [7:0] last_good = 8'h00;
    logic       prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rx_valid) begin
                n_valid++;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) check("rx_valid_unexpected", 1, 0);
                else check("rx_data", bus.rx_data, exp_q.pop_front());
            end
            if (bus.frame_err) n_ferr++;
            if (bus.msg_ok) begin
                n_ok++;
                check("msg_ok_timing", {bus.rx_valid, prev_valid}, 2'b01);
            end
        end
        prev_valid = bus.rx_valid;
    end

    // Inputs change 1 time unit after a rising edge and hold for n clocks
    task automatic hold(input logic v, input int n);
        bus.rx_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit push, input bit chg_div);
        int p;
        p = div + 1;
        if (push) begin
            exp_q.push_back(b);
            last_good = b;
        end
        start_cyc = cyc;
        hold(1'b0, p);
        if (chg_div) bus.custom_settings = DIV_W'(5);
        for (int i = 0; i < 8; i++) hold(b[i], p);
        hold(1'b1, p);
        bus.custom_settings = DIV_W'(div);
        hold(1'b1, 2);
    endtask

    task automatic snap();
        v0 = n_valid;
        f0 = n_ferr;
        k0 = n_ok;
    endtask

    initial begin
        bus.rx_in = 1'b1;
        bus.custom_settings = DIV_W'(15);
        #1;
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_busy", bus.rx_busy, 0);
        check("rst_msg_count", bus.msg_count, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(1'b1, 5);

        // 1: single byte, latency from start-bit edge to rx_valid
        snap();
        send_byte(8'h48, 1, 0);
        hold(1'b1, 10);
        check("t1_valid_cnt", n_valid - v0, 1);
        check("t1_ferr_cnt", n_ferr - f0, 0);
        check("t1_latency", last_valid_cyc - start_cyc, SYNC + 1 + (15 >> 1) + 1 + 9 * 16);

        // 2: three full messages
        snap();
        for (int m = 0; m < 3; m++)
            for (int c = 0; c < 11; c++) send_byte(MSG[c], 1, 0);
        hold(1'b1, 10);
        check("t2_valid_cnt", n_valid - v0, 33);
        check("t2_msg_ok_cnt", n_ok - k0, 3);
        check("t2_msg_count", bus.msg_count, 3);

        // 3: stop bit held low, then a clean frame
        snap();
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) hold(i[0] ? 1'b0 : 1'b1, 16);
        hold(1'b0, 40);
        hold(1'b1, 48);
        check("t3_ferr_cnt", n_ferr - f0, 1);
        check("t3_valid_cnt", n_valid - v0, 0);
        check("t3_rx_data_kept", bus.rx_data, last_good);
        send_byte(8'hA5, 1, 0);
        hold(1'b1, 10);
        check("t3_recover_cnt", n_valid - v0, 1);

        // 4: short low glitch is a false start
        snap();
        hold(1'b0, 4);
        hold(1'b1, 40);
        check("t4_valid_cnt", n_valid - v0, 0);
        check("t4_ferr_cnt", n_ferr - f0, 0);
        check("t4_busy", bus.rx_busy, 0);

        // 5: "HelH" resyncs on the second 'H'
        snap();
        send_byte(8'h48, 1, 0);
        send_byte(8'h65, 1, 0);
        send_byte(8'h6C, 1, 0);
        send_byte(8'h48, 1, 0);
        for (int c = 0; c < 11; c++) send_byte(MSG[c], 1, 0);
        hold(1'b1, 10);
        check("t5_msg_ok_cnt", n_ok - k0, 1);
        check("t5_msg_count", bus.msg_count, 4);

        // 6a: divisor change mid-frame is ignored
        snap();
        send_byte(8'hC3, 1, 1);
        hold(1'b1, 10);
        check("t6_divchg_cnt", n_valid - v0, 1);

        // 6b: reset in the middle of the data bits
        hold(1'b0, 16);
        hold(1'b1, 16);
        hold(1'b0, 5);
        check("t6_busy_mid", bus.rx_busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", bus.rx_busy, 0);
        check("t6_rst_msg_count", bus.msg_count, 0);
        check("t6_rst_rx_data", bus.rx_data, 0);
        check("t6_rst_strobes", {bus.rx_valid, bus.frame_err, bus.msg_ok}, 0);
        bus.rx_in = 1'b1;
        @(posedge clk);
        #1;
        hold(1'b1, 2);
        rst_n = 1'b1;
        last_good = 8'h00;
        snap();
        hold(1'b1, 200);
        check("t6_no_strobe_after_rst", (n_valid - v0) + (n_ferr - f0), 0);
        check("t6_msg_count_after", bus.msg_count, 0);

        // 6c: divisor below minimum keeps the receiver idle
        snap();
        div = 2;
        bus.custom_settings = DIV_W'(2);
        send_byte(8'h48, 0, 0);
        send_byte(8'h00, 0, 0);
        hold(1'b1, 20);
        check("t6_lowdiv_valid", n_valid - v0, 0);
        check("t6_lowdiv_ferr", n_ferr - f0, 0);
        check("t6_lowdiv_busy", bus.rx_busy, 0);
        div = 15;
        bus.custom_settings = DIV_W'(15);
        hold(1'b1, 5);

        // 6d: one-clock spike in bit 3
        snap();
        exp_q.push_back(8'h00);
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
`ifdef RX_MAJORITY_EN
                hold(1'b0, 8);
                hold(1'b1, 1);
                hold(1'b0, 7);
`else
                hold(1'b0, 3);
                hold(1'b1, 1);
                hold(1'b0, 12);
`endif
            end else begin
                hold(1'b0, 16);
            end
        end
        hold(1'b1, 20);
        check("t6_spike_valid", n_valid - v0, 1);

        hold(1'b1, 50);
        check("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
